instr_fetch_responder: RTL

//   Responder side of the instruction-fetch interface: accepts 16-bit word addresses from the fetch

---
 rtl/instr_fetch_responder_pkg.sv | 25 ++
 rtl/instr_fetch_responder_imem_array.sv | 59 +++++
 rtl/instr_fetch_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_responder_pkg.sv
// Shared types and widths for the instruction-fetch responder.
// IMEM_PARITY_EN widens each stored word with an even-parity bit.
package ifetch_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;
  localparam int CNT_W   = 4;

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = INSTR_W + 1;
`else
  localparam int MEM_W = INSTR_W;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic even_parity(input logic [INSTR_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/instr_fetch_responder_imem_array.sv
// Instruction store: synchronous write, asynchronous read, range/parity error flag.
// IMEM_PARITY_EN adds a stored parity bit and the i_par_inject corruption input.
module imem_array
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
`ifdef IMEM_PARITY_EN
  input  logic               i_par_inject,
`endif
  input  logic [ADDR_W-1:0]  i_raddr,
  output logic [INSTR_W-1:0] o_rdata,
  output logic               o_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);

  logic [MEM_W-1:0] r_mem [DEPTH];

  logic             w_wr_in_range;
  logic             w_rd_in_range;
  logic [MEM_W-1:0] w_wr_word;
  logic [MEM_W-1:0] w_rd_word;
  logic             w_par_err;

  assign w_wr_in_range = {1'b0, i_waddr} < DEPTH_C;
  assign w_rd_in_range = {1'b0, i_raddr} < DEPTH_C;

`ifdef IMEM_PARITY_EN
  assign w_wr_word = {even_parity(i_wdata) ^ i_par_inject, i_wdata};
`else
  assign w_wr_word = i_wdata;
`endif

  // Out-of-range writes are dropped rather than aliased onto a low address.
  always_ff @(posedge clk) begin
    if (i_we && w_wr_in_range) begin
      r_mem[i_waddr[IDX_W-1:0]] <= w_wr_word;
    end
  end

  assign w_rd_word = r_mem[i_raddr[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
  assign w_par_err = even_parity(w_rd_word[INSTR_W-1:0]) != w_rd_word[INSTR_W];
`else
  assign w_par_err = 1'b0;
`endif

  assign o_rdata = w_rd_in_range ? w_rd_word[INSTR_W-1:0] : '0;
  assign o_err   = !w_rd_in_range || w_par_err;

endmodule

// File: rtl/instr_fetch_responder.sv
// Fetch responder: one outstanding request, WAIT_STATES delay, flushable, with program-load port.
// IMEM_PARITY_EN adds the prog_par_inject port and parity checking on reads.
module instr_fetch_responder
  import ifetch_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               flush,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [INSTR_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0]  rsp_addr,
  output logic               rsp_err,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data
`ifdef IMEM_PARITY_EN
  ,
  input  logic               prog_par_inject
`endif
);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [INSTR_W-1:0] r_rsp_instr;
  logic [ADDR_W-1:0]  r_rsp_addr;
  logic               r_rsp_err;

  logic               w_accept;
  logic               w_enter_resp;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [INSTR_W-1:0] w_rd_data;
  logic               w_rd_err;

  // With zero wait states RESP is entered straight from IDLE, so read the live request address.
  assign w_rd_addr    = (r_state == IDLE) ? req_addr : r_addr;
  assign w_accept     = req_valid && req_ready;
  assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP);

  imem_array #(
    .DEPTH (DEPTH)
  ) u_imem (
    .clk          (clk),
    .i_we         (prog_we),
    .i_waddr      (prog_addr),
    .i_wdata      (prog_data),
`ifdef IMEM_PARITY_EN
    .i_par_inject (prog_par_inject),
`endif
    .i_raddr      (w_rd_addr),
    .o_rdata      (w_rd_data),
    .o_err        (w_rd_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (flush) begin
          w_next_state = IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        // flush wins over rsp_ready: the response is not delivered
        if (flush || rsp_ready) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == IDLE) && !flush;
    rsp_valid = (r_state == RESP);
  end

  // The store is sampled at the RESP-entry edge, so a same-edge write shows up only next fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_addr      <= '0;
      r_rsp_instr <= '0;
      r_rsp_addr  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= req_addr;
        r_cnt  <= CNT_W'(WAIT_STATES);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_enter_resp) begin
        r_rsp_instr <= w_rd_data;
        r_rsp_addr  <= w_rd_addr;
        r_rsp_err   <= w_rd_err;
      end
    end
  end

  assign rsp_instr = r_rsp_instr;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;

endmodule
